debug_control_unit: RTL and testbench

Command-driven debug controller between the UART receiver/transmitter and the MIPS pipeline. It decodes host command bytes, loads program words into instruction memory, gates the pipeline clock enable for continuous or step-by-step execution, and returns the PC to the host over the UART transmitter after each step or halt. It sits directly upstream of the MIPS core inside the top-level module.

---
 rtl/debug_control_unit_if.sv | 46 ++++
 rtl/debug_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_debug_control_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_control_unit_if
//  Description : Bundles the host-link and pipeline-side signals of the debug
//                control unit.
//                slave  : the debug control unit. It consumes the rx, halt,
//                         pc and tx-busy inputs and drives the tx, memory
//                         write, clock-enable, pipeline reset and state
//                         outputs.
//                master : the surrounding logic that drives the inputs.
//  Ports       : i_rx_data/i_rx_done (received byte + strobe), i_halt,
//                i_pc, i_tx_busy, o_tx_data/o_tx_start, o_mem_wr_en,
//                o_mem_addr, o_mem_data, o_clk_en, o_mips_reset, o_state
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_control_unit_if #(
    parameter int LEN    = 32,
    parameter int ADDR_W = 10
);
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              i_halt;
    logic [LEN-1:0]    i_pc;
    logic              i_tx_busy;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              o_mem_wr_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LEN-1:0]    o_mem_data;
    logic              o_clk_en;
    logic              o_mips_reset;
    logic [2:0]        o_state;

    modport slave (
        input  i_rx_data, i_rx_done, i_halt, i_pc, i_tx_busy,
        output o_tx_data, o_tx_start, o_mem_wr_en, o_mem_addr, o_mem_data,
               o_clk_en, o_mips_reset, o_state
    );

    modport master (
        output i_rx_data, i_rx_done, i_halt, i_pc, i_tx_busy,
        input  o_tx_data, o_tx_start, o_mem_wr_en, o_mem_addr, o_mem_data,
               o_clk_en, o_mips_reset, o_state
    );
endinterface
`default_nettype wire

// File: rtl/debug_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : debug_control_unit
//  Description : Command-driven debug controller between the UART and the
//                MIPS pipeline. It decodes host command bytes, loads program
//                words into instruction memory, gates the pipeline clock for
//                continuous or single-step execution, and returns the PC to
//                the host (MSB first) after each step or halt.
//  Ports       : CLK100MHZ    - system clock, rising edge
//                SWITCH_RESET - synchronous active-low reset
//                bus          - debug_control_unit_if.slave (rx byte/strobe,
//                               halt, pc, tx busy in; tx byte/start, memory
//                               write, clock enable, pipeline reset, state
//                               code out)
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_control_unit #(
    parameter int             LEN       = 32,
    parameter int             ADDR_W    = 10,
    parameter logic [LEN-1:0] HALT_WORD = {LEN{1'b1}}
) (
    input  wire logic              CLK100MHZ,
    input  wire logic              SWITCH_RESET,
    debug_control_unit_if.slave    bus
);

    localparam int NBYTES = LEN / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  ALL_BYTES = CNT_W'(NBYTES);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_CONT   = 8'h02;
    localparam logic [7:0] CMD_STEPBY = 8'h03;
    localparam logic [7:0] CMD_REPROG = 8'h05;
    localparam logic [7:0] CMD_STEP   = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PROGRAM    = 3'd1,
        ST_WAIT_MODE  = 3'd2,
        ST_CONTINUOUS = 3'd3,
        ST_STEP_IDLE  = 3'd4,
        ST_STEP_EXEC  = 3'd5,
        ST_SEND       = 3'd6
    } state_e;

    state_e            state_q, state_d;
    state_e            ret_q, ret_d;          // state to resume after SEND
    logic [LEN-1:0]    word_q, word_d;        // program word being assembled
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN-1:0]    mem_data_q, mem_data_d;
    logic [LEN-1:0]    pc_q, pc_d;            // PC snapshot, shifted left per byte
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;    // bytes already started
    logic              tx_gap_q, tx_gap_d;    // cycle after a start: busy not yet valid
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              clk_en_d;
    logic [LEN-1:0]    word_next;

    // Incoming byte appended as the least significant byte (MSB-first order).
    assign word_next = (word_q << 8) | LEN'(bus.i_rx_data);

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        pc_d       = pc_q;
        tx_cnt_d   = tx_cnt_q;
        tx_gap_d   = tx_gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        clk_en_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_REPROG) begin
                        state_d    = ST_PROGRAM;
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end else if (bus.i_rx_data == CMD_START) begin
                        state_d = ST_WAIT_MODE;
                    end
                end
            end

            ST_PROGRAM: begin
                if (bus.i_rx_done) begin
                    word_d = word_next;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        mem_addr_d = addr_q;
                        mem_data_d = word_next;
                        addr_d     = addr_q + 1'b1;
                        // The top address ends programming; the counter never wraps into use.
                        if (word_next == HALT_WORD || addr_q == ADDR_MAX) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_MODE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_CONT) begin
                        state_d = ST_CONTINUOUS;
                    end else if (bus.i_rx_data == CMD_STEPBY) begin
                        state_d = ST_STEP_IDLE;
                    end else if (bus.i_rx_data == CMD_REPROG) begin
                        state_d    = ST_PROGRAM;
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end
                end
            end

            ST_CONTINUOUS: begin
                clk_en_d = 1'b1;
                if (bus.i_halt) begin
                    state_d  = ST_SEND;
                    ret_d    = ST_IDLE;
                    pc_d     = bus.i_pc;
                    tx_cnt_d = '0;
                    tx_gap_d = 1'b0;
                end
            end

            ST_STEP_IDLE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_STEP) begin
                        state_d = ST_STEP_EXEC;
                    end else if (bus.i_rx_data == CMD_REPROG) begin
                        state_d    = ST_PROGRAM;
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end
                end
            end

            ST_STEP_EXEC: begin
                // A halt retired by this single step ends the debug session.
                clk_en_d = 1'b1;
                state_d  = ST_SEND;
                ret_d    = bus.i_halt ? ST_IDLE : ST_STEP_IDLE;
                pc_d     = bus.i_pc;
                tx_cnt_d = '0;
                tx_gap_d = 1'b0;
            end

            ST_SEND: begin
                if (tx_gap_q) begin
                    // Transmitter has not raised busy yet; skip this cycle.
                    tx_gap_d = 1'b0;
                    if (tx_cnt_q == ALL_BYTES) begin
                        state_d  = ret_q;
                        tx_cnt_d = '0;
                    end
                end else if (!bus.i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = pc_q[LEN-1 -: 8];
                    pc_d       = pc_q << 8;
                    tx_cnt_d   = tx_cnt_q + 1'b1;
                    tx_gap_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!SWITCH_RESET) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            word_q     <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            pc_q       <= '0;
            tx_cnt_q   <= '0;
            tx_gap_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            pc_q       <= pc_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_gap_q   <= tx_gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_mem_wr_en  = wr_en_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data   = mem_data_q;
    assign bus.o_clk_en     = clk_en_d;
    assign bus.o_mips_reset = (state_q == ST_IDLE) || (state_q == ST_PROGRAM);
    assign bus.o_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_control_unit
//  Description : Self-checking bench for debug_control_unit. Drives command
//                and program bytes, models the UART transmitter with random
//                busy lengths, and compares the memory writes, clock-enable
//                cycles and transmitted PC bytes against expectations derived
//                from the command protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_control_unit;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    debug_control_unit_if #(.LEN(32), .ADDR_W(10)) m ();
    debug_control_unit_if #(.LEN(32), .ADDR_W(2))  m2 ();

    debug_control_unit #(.LEN(32), .ADDR_W(10)) dut (
        .CLK100MHZ    (clk),
        .SWITCH_RESET (rstn),
        .bus          (m)
    );

    debug_control_unit #(.LEN(32), .ADDR_W(2)) dut2 (
        .CLK100MHZ    (clk),
        .SWITCH_RESET (rstn),
        .bus          (m2)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  txq[$];
    logic [31:0] waddr_q[$], wdata_q[$];
    logic [31:0] waddr2_q[$], wdata2_q[$];
    int          ce_cnt = 0;
    int          viol = 0;
    int          tx_cnt = 0;
    logic        busy_hold = 1'b0;

    assign m.i_tx_busy  = busy_hold | (tx_cnt != 0);
    assign m2.i_tx_busy = 1'b0;
    assign m2.i_halt    = 1'b0;
    assign m2.i_pc      = '0;

    // Transmitter model plus write / clock-enable recorders.
    always @(posedge clk) begin
        if (m.o_tx_start) begin
            if (m.i_tx_busy) viol <= viol + 1;
            txq.push_back(m.o_tx_data);
            tx_cnt <= int'($urandom_range(1, 6));
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        if (m.o_clk_en) ce_cnt <= ce_cnt + 1;
        if (m.o_mem_wr_en) begin
            waddr_q.push_back(32'(m.o_mem_addr));
            wdata_q.push_back(m.o_mem_data);
        end
        if (m2.o_mem_wr_en) begin
            waddr2_q.push_back(32'(m2.o_mem_addr));
            wdata2_q.push_back(m2.o_mem_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (!sel) begin m.i_rx_data = b; m.i_rx_done = 1'b1; end
        else begin m2.i_rx_data = b; m2.i_rx_done = 1'b1; end
        @(negedge clk);
        m.i_rx_done  = 1'b0;
        m2.i_rx_done = 1'b0;
        m.i_rx_data  = 8'($urandom);
        m2.i_rx_data = 8'($urandom);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send(sel, w[8*i +: 8]);
            tick(int'($urandom_range(0, 2)));
        end
    endtask

    // Bytes kept in 0x10..0xFE: never a command code, never the halt word.
    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(16, 254));
        return w;
    endfunction

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        for (int i = 0; i < budget && m.o_state !== st; i++) @(negedge clk);
        check(tag, 64'(m.o_state), 64'(st));
    endtask

    // Expected writes: sequential addresses from 0, stopping after the halt
    // word or after the last address of the memory.
    task automatic check_writes(input bit sel, input logic [31:0] words[$], input int aw,
                                input int base, input string tag);
        logic [31:0] ea[$], ed[$];
        logic [31:0] oa, od;
        int addr = 0;
        int n;
        foreach (words[i]) begin
            ea.push_back(32'(addr));
            ed.push_back(words[i]);
            if (words[i] == 32'hFFFF_FFFF || addr == (1 << aw) - 1) break;
            addr++;
        end
        n = sel ? wdata2_q.size() : wdata_q.size();
        check({tag, "_count"}, 64'(n - base), 64'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            oa = 'x; od = 'x;
            if (base + i < n) begin
                oa = sel ? waddr2_q[base + i] : waddr_q[base + i];
                od = sel ? wdata2_q[base + i] : wdata_q[base + i];
            end
            check({tag, "_addr"}, 64'(oa), 64'(ea[i]));
            check({tag, "_data"}, 64'(od), 64'(ed[i]));
        end
    endtask

    task automatic check_tx(input int base, input logic [31:0] pc, input string tag);
        logic [7:0] ob;
        check({tag, "_txcount"}, 64'(txq.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ob = 'x;
            if (base + i < txq.size()) ob = txq[base + i];
            check({tag, "_txbyte"}, 64'(ob), 64'(pc[31 - 8*i -: 8]));
        end
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] pcs[$];
        logic [31:0] pc;
        int wb, ceb, txb;

        rstn = 1'b0;
        m.i_rx_data = '0;  m.i_rx_done = 1'b0;  m.i_halt = 1'b0;  m.i_pc = '0;
        m2.i_rx_data = '0; m2.i_rx_done = 1'b0;
        tick(3);

        // Reset values
        check("rst_state",    64'(m.o_state),      64'd0);
        check("rst_mipsrst",  64'(m.o_mips_reset), 64'd1);
        check("rst_clken",    64'(m.o_clk_en),     64'd0);
        check("rst_wren",     64'(m.o_mem_wr_en),  64'd0);
        check("rst_txstart",  64'(m.o_tx_start),   64'd0);
        check("rst_txdata",   64'(m.o_tx_data),    64'd0);
        check("rst_memaddr",  64'(m.o_mem_addr),   64'd0);
        check("rst_memdata",  64'(m.o_mem_data),   64'd0);
        rstn = 1'b1;
        tick(2);

        // Fixed program from the test plan
        wb = wdata_q.size();
        send(0, 8'h05);
        check("prog_enter", 64'(m.o_state), 64'd1);
        words = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
        foreach (words[i]) send_word(0, words[i]);
        tick(2);
        check_writes(0, words, 10, wb, "prog_fixed");
        check("prog_exit", 64'(m.o_state), 64'd0);

        // Random program ending in the halt word
        wb = wdata_q.size();
        send(0, 8'h05);
        words = '{rand_word(), rand_word(), rand_word(), 32'hFFFF_FFFF};
        foreach (words[i]) send_word(0, words[i]);
        tick(2);
        check_writes(0, words, 10, wb, "prog_rand");
        check("prog_rand_exit", 64'(m.o_state), 64'd0);

        // Reset in the middle of a word
        wb = wdata_q.size();
        send(0, 8'h05);
        send(0, 8'h11);
        send(0, 8'h22);
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        check("midrst_state", 64'(m.o_state), 64'd0);
        check("midrst_nowrite", 64'(wdata_q.size() - wb), 64'd0);
        check("midrst_addr", 64'(m.o_mem_addr), 64'd0);
        wb = wdata_q.size();
        send(0, 8'h05);
        words = '{rand_word(), 32'hFFFF_FFFF};
        foreach (words[i]) send_word(0, words[i]);
        tick(2);
        check_writes(0, words, 10, wb, "midrst_reprog");

        // Continuous run, halt raised 40 cycles in
        send(0, 8'h01);
        check("cont_wait", 64'(m.o_state), 64'd2);
        send(0, 8'h02);
        check("cont_run", 64'(m.o_state), 64'd3);
        ceb = ce_cnt; txb = txq.size();
        m.i_pc = 32'h0000_000C;
        tick(40);
        m.i_halt = 1'b1;
        @(negedge clk);
        m.i_pc = $urandom;
        wait_state(3'd0, 300, "cont_end");
        check("cont_clken_cycles", 64'(ce_cnt - ceb), 64'd41);
        check("cont_mipsrst", 64'(m.o_mips_reset), 64'd1);
        check_tx(txb, 32'h0000_000C, "cont");
        m.i_halt = 1'b0;

        // Step-by-step
        send(0, 8'h01);
        send(0, 8'h03);
        check("step_idle", 64'(m.o_state), 64'd4);
        send(0, 8'h02);
        tick(2);
        check("step_stray", 64'(m.o_state), 64'd4);
        pcs = '{32'd4, 32'd8, 32'd12, $urandom, $urandom};
        foreach (pcs[k]) begin
            pc = pcs[k];
            ceb = ce_cnt; txb = txq.size();
            m.i_pc = pc;
            send(0, 8'h06);
            check("step_exec", 64'(m.o_state), 64'd5);
            @(negedge clk);
            m.i_pc = $urandom;
            wait_state(3'd4, 300, "step_back");
            check("step_clken", 64'(ce_cnt - ceb), 64'd1);
            check_tx(txb, pc, "step");
        end

        // Halt arriving together with a step command
        pc = $urandom;
        ceb = ce_cnt; txb = txq.size();
        m.i_pc = pc;
        m.i_halt = 1'b1;
        send(0, 8'h06);
        check("sthalt_exec", 64'(m.o_state), 64'd5);
        @(negedge clk);
        m.i_pc = $urandom;
        wait_state(3'd0, 300, "sthalt_idle");
        check("sthalt_clken", 64'(ce_cnt - ceb), 64'd1);
        check_tx(txb, pc, "sthalt");
        m.i_halt = 1'b0;

        // Transmitter backpressure for 100 cycles
        send(0, 8'h01);
        send(0, 8'h02);
        busy_hold = 1'b1;
        pc = $urandom;
        m.i_pc = pc;
        txb = txq.size();
        m.i_halt = 1'b1;
        @(negedge clk);
        m.i_pc = $urandom;
        tick(100);
        check("bp_nostart", 64'(txq.size() - txb), 64'd0);
        check("bp_insend", 64'(m.o_state), 64'd6);
        busy_hold = 1'b0;
        wait_state(3'd0, 300, "bp_end");
        check_tx(txb, pc, "bp");
        check("bp_start_while_busy", 64'(viol), 64'd0);
        m.i_halt = 1'b0;

        // Address limit on the 4-entry instance
        wb = wdata2_q.size();
        send(1, 8'h05);
        check("lim_enter", 64'(m2.o_state), 64'd1);
        words = '{rand_word(), rand_word(), rand_word(), rand_word(), rand_word()};
        foreach (words[i]) send_word(1, words[i]);
        tick(2);
        check_writes(1, words, 2, wb, "lim");
        check("lim_exit", 64'(m2.o_state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
